grid_scanout: RTL

Video-side reader of the 22×10 playfield produced by the game FSM. It snapshots the board at each frame start so a frame never shows a half-updated board. It then walks the snapshot in raster order using cell and sub-pixel counters, with no dividers. It emits one registered `pixel_on` per pixel clock to the colour mux ahead of the VGA output stage.

---
 rtl/grid_scanout.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/grid_scanout.sv
// Raster scan-out of the 22x10 playfield: per-frame snapshot, divider-free cell walkers, 2-stage pixel pipeline.
// Optional build macro GRID_SCANOUT_GRIDLINES_EN darkens the first pixel row/column of every cell.
module grid_scanout #(
  parameter int unsigned X_ORIGIN = 220,
  parameter int unsigned Y_ORIGIN = 20,
  parameter int unsigned CELL_PX  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [21:0][9:0]  display_array,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              active,
  input  logic              frame_start,
  output logic              pixel_on,
  output logic              in_board,
  output logic [4:0]        cell_row,
  output logic [3:0]        cell_col
);

  localparam int unsigned ROWS = 22;
  localparam int unsigned COLS = 10;
  localparam logic [9:0]  X0       = 10'(X_ORIGIN);
  localparam logic [9:0]  Y0       = 10'(Y_ORIGIN);
  localparam logic [4:0]  SUB_LAST = 5'(CELL_PX - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [3:0]  COL_LAST = 4'(COLS - 1);

  logic [21:0][9:0] snap;

  logic [3:0] col_cnt, col_nxt;
  logic [4:0] hsub, hsub_nxt;
  logic       h_in, h_in_nxt;
  logic [4:0] row_cnt, row_nxt;
  logic [4:0] vsub, vsub_nxt;
  logic       v_in, v_in_nxt;

  logic       s1_hit;
  logic [4:0] s1_row;
  logic [3:0] s1_col;
  logic       s1_lit;
`ifdef GRID_SCANOUT_GRIDLINES_EN
  logic       s1_gut;
`endif

  // Horizontal walker; the *_nxt values describe the pixel presented this cycle.
  always_comb begin
    col_nxt  = col_cnt;
    hsub_nxt = hsub;
    h_in_nxt = h_in;
    if (hcount == X0) begin
      col_nxt  = '0;
      hsub_nxt = '0;
      h_in_nxt = 1'b1;
    end else if (h_in) begin
      if (hsub == SUB_LAST) begin
        hsub_nxt = '0;
        if (col_cnt == COL_LAST) begin
          h_in_nxt = 1'b0;
        end else begin
          col_nxt = col_cnt + 4'd1;
        end
      end else begin
        hsub_nxt = hsub + 5'd1;
      end
    end
  end

  // Vertical walker advances only on the line-start cycle.
  always_comb begin
    row_nxt  = row_cnt;
    vsub_nxt = vsub;
    v_in_nxt = v_in;
    if (hcount == 10'd0) begin
      if (vcount == Y0) begin
        row_nxt  = '0;
        vsub_nxt = '0;
        v_in_nxt = 1'b1;
      end else if (v_in) begin
        if (vsub == SUB_LAST) begin
          vsub_nxt = '0;
          if (row_cnt == ROW_LAST) begin
            v_in_nxt = 1'b0;
          end else begin
            row_nxt = row_cnt + 5'd1;
          end
        end else begin
          vsub_nxt = vsub + 5'd1;
        end
      end
    end
  end

  // Stage-2 cell lookup against the current snapshot.
  always_comb begin
    s1_lit = s1_hit & snap[s1_row][s1_col];
`ifdef GRID_SCANOUT_GRIDLINES_EN
    if (s1_gut) begin
      s1_lit = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      col_cnt  <= '0;
      hsub     <= '0;
      h_in     <= 1'b0;
      row_cnt  <= '0;
      vsub     <= '0;
      v_in     <= 1'b0;
      s1_hit   <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
`ifdef GRID_SCANOUT_GRIDLINES_EN
      s1_gut   <= 1'b0;
`endif
      pixel_on <= 1'b0;
      in_board <= 1'b0;
      cell_row <= '0;
      cell_col <= '0;
    end else begin
      if (frame_start) begin
        snap <= display_array;
      end
      col_cnt  <= col_nxt;
      hsub     <= hsub_nxt;
      h_in     <= h_in_nxt;
      row_cnt  <= row_nxt;
      vsub     <= vsub_nxt;
      v_in     <= v_in_nxt;
      s1_hit   <= h_in_nxt & v_in_nxt & active;
      s1_row   <= row_nxt;
      s1_col   <= col_nxt;
`ifdef GRID_SCANOUT_GRIDLINES_EN
      s1_gut   <= (hsub_nxt == 5'd0) | (vsub_nxt == 5'd0);
`endif
      pixel_on <= s1_lit;
      in_board <= s1_hit;
      cell_row <= s1_hit ? s1_row : 5'd0;
      cell_col <= s1_hit ? s1_col : 4'd0;
    end
  end

endmodule
